// File: rtl/match_round_controller.sv
// match_round_controller: scores rounds from both players' states, times the
// post-round pause, issues a one-frame active-low round reset, and declares a
// match winner after ROUNDS_TO_WIN round wins.
// Optional build macro: MATCH_ROUND_TIMER_EN adds a round timer that declares a
// draw when a round runs ROUND_FRAMES frames, plus the round_time_left output.
module match_round_controller #(
    parameter int unsigned             STATE_DEPTH     = 4,
    parameter logic [STATE_DEPTH-1:0]  WIN_STATE       = STATE_DEPTH'(9),
    parameter int unsigned             WIN_FRAMES_WAIT = 120,
    parameter int unsigned             ROUNDS_TO_WIN   = 2,
    parameter int unsigned             ROUND_FRAMES    = 5400,
    parameter int unsigned             SCORE_DEPTH     = 2
) (
    input  logic                              frame_clk,
    input  logic                              reset,
    input  logic [STATE_DEPTH-1:0]            p1_state,
    input  logic [STATE_DEPTH-1:0]            p2_state,
    input  logic                              start,
    output logic                              round_reset_n,
    output logic [1:0]                        round_result,
    output logic [SCORE_DEPTH-1:0]            p1_score,
    output logic [SCORE_DEPTH-1:0]            p2_score,
    output logic                              match_over,
    output logic [1:0]                        match_winner
`ifdef MATCH_ROUND_TIMER_EN
    ,
    output logic [$clog2(ROUND_FRAMES)-1:0]   round_time_left
`endif
);

    localparam int unsigned PAUSE_W = $clog2(WIN_FRAMES_WAIT);

    localparam logic [PAUSE_W-1:0]     PAUSE_LAST = PAUSE_W'(WIN_FRAMES_WAIT - 1);
    localparam logic [SCORE_DEPTH-1:0] SCORE_MAX  = SCORE_DEPTH'(ROUNDS_TO_WIN);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Reject parameter sets the counters cannot represent
    if (WIN_FRAMES_WAIT < 2) begin : g_bad_wait
        $error("WIN_FRAMES_WAIT must be at least 2");
    end
    if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN >= (1 << SCORE_DEPTH)) begin : g_bad_score
        $error("ROUNDS_TO_WIN must be >= 1 and fit in SCORE_DEPTH bits");
    end
    if (ROUND_FRAMES < 2) begin : g_bad_round
        $error("ROUND_FRAMES must be at least 2");
    end

    typedef enum logic [1:0] {
        FIGHT       = 2'd0,
        PAUSE       = 2'd1,
        RESET_PULSE = 2'd2,
        MATCH_OVER  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SCORE_DEPTH-1:0] p1_score_q, p1_score_d;
    logic [SCORE_DEPTH-1:0] p2_score_q, p2_score_d;
    logic [PAUSE_W-1:0]     pause_cnt_q, pause_cnt_d;
    logic [1:0]             round_result_q, round_result_d;
    logic [1:0]             match_winner_q, match_winner_d;
    logic                   round_reset_n_q, round_reset_n_d;
    logic                   match_over_q, match_over_d;

    logic p1_win;
    logic p2_win;

`ifdef MATCH_ROUND_TIMER_EN
    localparam int unsigned          TIMER_W    = $clog2(ROUND_FRAMES);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(ROUND_FRAMES - 1);

    logic [TIMER_W-1:0] round_timer_q, round_timer_d;
    logic [TIMER_W-1:0] time_left_q, time_left_d;
`endif

    assign p1_win = (p1_state == WIN_STATE);
    assign p2_win = (p2_state == WIN_STATE);

    // Next-state, scoring and registered-output decode
    always_comb begin
        state_d        = state_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        pause_cnt_d    = pause_cnt_q;
        round_result_d = round_result_q;
        match_winner_d = match_winner_q;
`ifdef MATCH_ROUND_TIMER_EN
        round_timer_d  = round_timer_q;
`endif

        case (state_q)
            FIGHT: begin
                if (p1_win && p2_win) begin
                    round_result_d = RES_DRAW;
                    pause_cnt_d    = '0;
                    state_d        = PAUSE;
                end else if (p1_win) begin
                    p1_score_d     = (p1_score_q == SCORE_MAX) ? p1_score_q
                                                               : p1_score_q + SCORE_DEPTH'(1);
                    round_result_d = RES_P1;
                    pause_cnt_d    = '0;
                    state_d        = PAUSE;
                end else if (p2_win) begin
                    p2_score_d     = (p2_score_q == SCORE_MAX) ? p2_score_q
                                                               : p2_score_q + SCORE_DEPTH'(1);
                    round_result_d = RES_P2;
                    pause_cnt_d    = '0;
                    state_d        = PAUSE;
                end else begin
`ifdef MATCH_ROUND_TIMER_EN
                    // A win on the timeout frame is handled above and takes priority
                    if (round_timer_q == TIMER_LAST) begin
                        round_result_d = RES_DRAW;
                        pause_cnt_d    = '0;
                        state_d        = PAUSE;
                    end else begin
                        round_timer_d = round_timer_q + TIMER_W'(1);
                    end
`endif
                end
            end

            PAUSE: begin
                // Player states are ignored here so a held WIN scores only once
                pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
                if (pause_cnt_q == PAUSE_LAST) begin
                    if (p1_score_q == SCORE_MAX) begin
                        match_winner_d = RES_P1;
                        state_d        = MATCH_OVER;
                    end else if (p2_score_q == SCORE_MAX) begin
                        match_winner_d = RES_P2;
                        state_d        = MATCH_OVER;
                    end else begin
                        state_d = RESET_PULSE;
                    end
                end
            end

            RESET_PULSE: begin
`ifdef MATCH_ROUND_TIMER_EN
                round_timer_d  = '0;
`endif
                round_result_d = RES_NONE;
                state_d        = FIGHT;
            end

            MATCH_OVER: begin
                if (start) begin
                    p1_score_d     = '0;
                    p2_score_d     = '0;
                    match_winner_d = RES_NONE;
                    round_result_d = RES_NONE;
                    state_d        = RESET_PULSE;
                end
            end

            default: begin
                state_d = FIGHT;
            end
        endcase

        round_reset_n_d = (state_d != RESET_PULSE);
        match_over_d    = (state_d == MATCH_OVER);
`ifdef MATCH_ROUND_TIMER_EN
        time_left_d     = (state_d == FIGHT) ? (TIMER_LAST - round_timer_d) : '0;
`endif
    end

    // State and output registers
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= FIGHT;
            p1_score_q      <= '0;
            p2_score_q      <= '0;
            pause_cnt_q     <= '0;
            round_result_q  <= RES_NONE;
            match_winner_q  <= RES_NONE;
            round_reset_n_q <= 1'b1;
            match_over_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            p1_score_q      <= p1_score_d;
            p2_score_q      <= p2_score_d;
            pause_cnt_q     <= pause_cnt_d;
            round_result_q  <= round_result_d;
            match_winner_q  <= match_winner_d;
            round_reset_n_q <= round_reset_n_d;
            match_over_q    <= match_over_d;
        end
    end

`ifdef MATCH_ROUND_TIMER_EN
    // Round timer and remaining-time registers
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            round_timer_q <= '0;
            time_left_q   <= TIMER_LAST;
        end else begin
            round_timer_q <= round_timer_d;
            time_left_q   <= time_left_d;
        end
    end

    assign round_time_left = time_left_q;
`endif

    assign round_reset_n = round_reset_n_q;
    assign round_result  = round_result_q;
    assign p1_score      = p1_score_q;
    assign p2_score      = p2_score_q;
    assign match_over    = match_over_q;
    assign match_winner  = match_winner_q;

endmodule

// File: tb/tb_match_round_controller.sv
// Scoreboard bench for match_round_controller (WIN_FRAMES_WAIT=4,
// ROUNDS_TO_WIN=2, ROUND_FRAMES=8). Stimulus pushes hand-computed expected
// outputs; a monitor pops and compares one entry per frame edge or reset edge.
module tb_match_round_controller;

    localparam int unsigned SD  = 4;
    localparam int unsigned WFW = 4;
    localparam int unsigned RTW = 2;
    localparam int unsigned RF  = 8;
    localparam int unsigned SCD = 2;
    localparam int unsigned TW  = $clog2(RF);

    logic           frame_clk = 1'b0;
    logic           reset     = 1'b0;
    logic           start     = 1'b0;
    logic [SD-1:0]  p1_state  = '0;
    logic [SD-1:0]  p2_state  = '0;
    logic           round_reset_n;
    logic [1:0]     round_result;
    logic [SCD-1:0] p1_score;
    logic [SCD-1:0] p2_score;
    logic           match_over;
    logic [1:0]     match_winner;
`ifdef MATCH_ROUND_TIMER_EN
    logic [TW-1:0]  round_time_left;
`endif

    match_round_controller #(
        .STATE_DEPTH     (SD),
        .WIN_STATE       (4'd9),
        .WIN_FRAMES_WAIT (WFW),
        .ROUNDS_TO_WIN   (RTW),
        .ROUND_FRAMES    (RF),
        .SCORE_DEPTH     (SCD)
    ) dut (
        .frame_clk       (frame_clk),
        .reset           (reset),
        .p1_state        (p1_state),
        .p2_state        (p2_state),
        .start           (start),
        .round_reset_n   (round_reset_n),
        .round_result    (round_result),
        .p1_score        (p1_score),
        .p2_score        (p2_score),
        .match_over      (match_over),
        .match_winner    (match_winner)
`ifdef MATCH_ROUND_TIMER_EN
        ,
        .round_time_left (round_time_left)
`endif
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string         name;
        logic          rr_n;
        logic [1:0]    res;
        logic [1:0]    s1;
        logic [1:0]    s2;
        logic          mo;
        logic [1:0]    mw;
        logic          tl_chk;
        logic [TW-1:0] tl;
    } exp_t;

    exp_t exp_q[$];
    exp_t ev;
    int   checks = 0;
    int   errors = 0;

    // Set the expected output picture for the following frame(s)
    task automatic set_exp(input int rr, input int res, input int s1, input int s2,
                           input int mo, input int mw);
        ev.rr_n = 1'(rr);
        ev.res  = 2'(res);
        ev.s1   = 2'(s1);
        ev.s2   = 2'(s2);
        ev.mo   = 1'(mo);
        ev.mw   = 2'(mw);
    endtask

    // Drive one frame of inputs and queue the outputs expected after its edge
    task automatic step(input int a, input int b, input int st, input int rst, input string nm);
        @(posedge frame_clk);
        #2;
        p1_state = SD'(a);
        p2_state = SD'(b);
        start    = (st != 0);
        reset    = (rst != 0);
        ev.name  = nm;
        exp_q.push_back(ev);
    endtask

    // Monitor: compare DUT outputs just after every frame edge or reset assertion
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge frame_clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                bad = (round_reset_n !== e.rr_n) || (round_result !== e.res) ||
                      (p1_score !== e.s1) || (p2_score !== e.s2) ||
                      (match_over !== e.mo) || (match_winner !== e.mw);
`ifdef MATCH_ROUND_TIMER_EN
                if (e.tl_chk && (round_time_left !== e.tl)) bad = 1'b1;
`endif
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s @%0t: got rr_n=%b res=%b s1=%0d s2=%0d mo=%b mw=%b, expected rr_n=%b res=%b s1=%0d s2=%0d mo=%b mw=%b",
                             e.name, $time, round_reset_n, round_result, p1_score, p2_score,
                             match_over, match_winner, e.rr_n, e.res, e.s1, e.s2, e.mo, e.mw);
`ifdef MATCH_ROUND_TIMER_EN
                    $display("  %s time_left: got %0d, expected %0d (checked=%b)",
                             e.name, round_time_left, e.tl, e.tl_chk);
`endif
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        ev.tl_chk = 1'b0;
        ev.tl     = '0;

        // 1: reset state, single P1 win, pause and reset pulse timing
        set_exp(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, "t1_reset_hold");
        step(0, 0, 0, 1, "t1_release_idle");
        set_exp(1, 1, 1, 0, 0, 0);
        step(9, 0, 0, 1, "t1_p1_win");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "t1_pause");
        set_exp(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, "t1_pulse");
        set_exp(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, "t1_fight");

        // 2: second P1 win ends the match; start restarts it
        set_exp(1, 1, 2, 0, 0, 0);
        step(9, 0, 0, 1, "t2_p1_win2");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "t2_pause");
        set_exp(1, 1, 2, 0, 1, 1);
        step(0, 0, 0, 1, "t2_match_over");
        step(9, 9, 0, 1, "t2_over_hold");
        set_exp(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, "t2_restart_pulse");
        set_exp(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, "t2_fight");

        // 3: simultaneous win is a draw
        set_exp(1, 3, 0, 0, 0, 0);
        step(9, 9, 0, 1, "t3_draw");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "t3_pause");
        set_exp(0, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, "t3_pulse");
        set_exp(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, "t3_fight");

        // 4: held P2 win scores once; start ignored in FIGHT and PAUSE
        step(0, 0, 1, 1, "t4_start_in_fight");
        set_exp(1, 2, 0, 1, 0, 0);
        step(0, 9, 0, 1, "t4_p2_win");
        step(0, 9, 1, 1, "t4_start_in_pause");
        step(0, 9, 0, 1, "t4_hold");
        step(0, 9, 0, 1, "t4_hold");
        set_exp(0, 2, 0, 1, 0, 0);
        step(0, 9, 0, 1, "t4_pulse_held");
        set_exp(1, 0, 0, 1, 0, 0);
        step(0, 9, 0, 1, "t4_fight");
        step(0, 0, 0, 1, "t4_idle");

        // 5: asynchronous reset on pause frame 2, then scoring restarts from zero
        set_exp(1, 1, 1, 1, 0, 0);
        step(9, 0, 0, 1, "t5_p1_win");
        step(0, 0, 0, 1, "t5_pause1");
        @(posedge frame_clk);
        #2;
        set_exp(1, 0, 0, 0, 0, 0);
        ev.name = "t5_async_reset";
        exp_q.push_back(ev);
        #1 reset = 1'b0;
        #3;
        step(0, 0, 0, 0, "t5_reset_hold");
        step(0, 0, 0, 1, "t5_release");
        set_exp(1, 1, 1, 0, 0, 0);
        step(9, 0, 0, 1, "t5_win_from_zero");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "t5_pause");
        set_exp(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, "t5_pulse");
        set_exp(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, "t5_fight");

`ifdef MATCH_ROUND_TIMER_EN
        // 6: timeout draw on frame 8, then a win on frame 8 beats the timeout
        ev.tl_chk = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            ev.tl = TW'(7 - i);
            step(0, 0, 0, 1, "t6_countdown");
        end
        set_exp(1, 3, 1, 0, 0, 0);
        ev.tl = '0;
        step(0, 0, 0, 1, "t6_timeout_draw");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "t6_pause");
        set_exp(0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 1, "t6_pulse");
        set_exp(1, 0, 1, 0, 0, 0);
        ev.tl = TW'(7);
        step(0, 0, 0, 1, "t6_fight_full");
        for (int i = 1; i <= 7; i++) begin
            ev.tl = TW'(7 - i);
            step(0, 0, 0, 1, "t6_countdown2");
        end
        set_exp(1, 1, 2, 0, 0, 0);
        ev.tl = '0;
        step(9, 0, 0, 1, "t6_win_on_timeout");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "t6_pause2");
        set_exp(1, 1, 2, 0, 1, 1);
        step(0, 0, 0, 1, "t6_match_over");
`endif

        repeat (3) @(posedge frame_clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
